// File: rtl/isa_fetch_ctrl_if.sv
// Bus bundle for isa_fetch_ctrl: one GLB read port plus the ISA word stream to the CCU.
// The master side is the fetch controller; the slave side is the GLB/CCU environment.
interface isa_fetch_ctrl_if #(
  parameter int PORT_WIDTH = 128,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] GLB_RdAddr;
  logic                  GLB_RdAddrVld;
  logic                  GLB_RdAddrRdy;
  logic [PORT_WIDTH-1:0] GLB_RdDat;
  logic                  GLB_RdDatVld;
  logic [PORT_WIDTH-1:0] ISA_OutDat;
  logic                  ISA_OutDatVld;
  logic                  ISA_OutDatRdy;

  modport master (
    output GLB_RdAddr, GLB_RdAddrVld,
    input  GLB_RdAddrRdy, GLB_RdDat, GLB_RdDatVld,
    output ISA_OutDat, ISA_OutDatVld,
    input  ISA_OutDatRdy
  );

  modport slave (
    input  GLB_RdAddr, GLB_RdAddrVld,
    output GLB_RdAddrRdy, GLB_RdDat, GLB_RdDatVld,
    input  ISA_OutDat, ISA_OutDatVld,
    output ISA_OutDatRdy
  );
endinterface

// File: rtl/isa_fetch_ctrl.sv
// Streams a block of ISA words from a GLB read port into the CCU ISA input.
// Reads are credit-limited so the FWFT buffer can never overflow.
module isa_fetch_ctrl #(
  parameter int PORT_WIDTH      = 128,
  parameter int ADDR_WIDTH      = 16,
  parameter int NUMWORD_WIDTH   = 16,
  parameter int FIFO_ADDR_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     TOP_Start,
  input  logic [ADDR_WIDTH-1:0]    TOP_BaseAddr,
  input  logic [NUMWORD_WIDTH-1:0] TOP_NumWord,
  output logic                     TOP_Busy,
  output logic                     TOP_Done,
  output logic                     TOP_Err,
  isa_fetch_ctrl_if.master         bus
);
  localparam int D  = 1 << FIFO_ADDR_WIDTH;
  localparam int CW = FIFO_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = CW'(D);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                     r_state;
  logic [ADDR_WIDTH-1:0]      r_addr;
  logic [NUMWORD_WIDTH-1:0]   r_num;
  logic [NUMWORD_WIDTH-1:0]   r_issued;
  logic [CW-1:0]              r_outstanding;
  logic [CW-1:0]              r_count;
  logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
  logic [PORT_WIDTH-1:0]      r_mem [D];
  logic                       r_err;

  logic [CW-1:0] w_credit;
  logic          w_addr_vld;
  logic          w_addr_hs;
  logic          w_last_hs;
  logic          w_push;
  logic          w_pop;
  logic          w_drained;

  // Buffer slots not yet claimed by stored words or by reads still in flight.
  assign w_credit   = DEPTH - r_count - r_outstanding;
  assign w_addr_vld = (r_state == FETCH) && (r_issued < r_num) && (w_credit != '0);
  assign w_addr_hs  = w_addr_vld && bus.GLB_RdAddrRdy;
  assign w_last_hs  = w_addr_hs && (r_issued == r_num - 1'b1);
  assign w_push     = bus.GLB_RdDatVld && (r_outstanding != '0);
  assign w_pop      = (r_count != '0) && bus.ISA_OutDatRdy;
  // Empty after this cycle's pop, so DONE follows the last output handshake directly.
  assign w_drained  = (r_outstanding == '0) && !w_push &&
                      ((r_count == '0) || ((r_count == CW'(1)) && w_pop));

  assign bus.GLB_RdAddr    = r_addr;
  assign bus.GLB_RdAddrVld = w_addr_vld;
  assign bus.ISA_OutDat    = r_mem[r_rd_ptr];
  assign bus.ISA_OutDatVld = (r_count != '0);
  assign TOP_Busy          = (r_state != IDLE);
  assign TOP_Done          = (r_state == DONE);
  assign TOP_Err           = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_num    <= '0;
      r_issued <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (TOP_Start) begin
            if (TOP_NumWord != '0) begin
              r_addr   <= TOP_BaseAddr;
              r_num    <= TOP_NumWord;
              r_issued <= '0;
              r_state  <= FETCH;
            end else begin
              r_state <= DONE;
            end
          end
        end
        FETCH: begin
          if (w_addr_hs) begin
            r_addr   <= r_addr + 1'b1;
            r_issued <= r_issued + 1'b1;
            if (w_last_hs) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_drained) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_addr_hs) - CW'(w_push);
      // Data with nothing outstanding is dropped and flagged until reset.
      if (bus.GLB_RdDatVld && (r_outstanding == '0)) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < D; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.GLB_RdDat;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_isa_fetch_ctrl.sv
// Scoreboard bench for isa_fetch_ctrl: a latency-programmable GLB model plus
// expected-address and expected-word queues filled when each launch is driven.
module tb_isa_fetch_ctrl;
  localparam int PW = 128;
  localparam int AW = 16;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          TOP_Start = 1'b0;
  logic [AW-1:0] TOP_BaseAddr = '0;
  logic [NW-1:0] TOP_NumWord = '0;
  logic          TOP_Busy;
  logic          TOP_Done;
  logic          TOP_Err;

  isa_fetch_ctrl_if #(.PORT_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();

  isa_fetch_ctrl #(
    .PORT_WIDTH(PW), .ADDR_WIDTH(AW), .NUMWORD_WIDTH(NW), .FIFO_ADDR_WIDTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .TOP_Start(TOP_Start), .TOP_BaseAddr(TOP_BaseAddr), .TOP_NumWord(TOP_NumWord),
    .TOP_Busy(TOP_Busy), .TOP_Done(TOP_Done), .TOP_Err(TOP_Err),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [PW-1:0] dat;
  } ret_t;

  ret_t          pend_q[$];
  logic [PW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int t_start = 0;
  int lat_cur = 2;
  int hold_until = 0;
  int hold_check = -1;
  int hs_cnt = 0;
  int first_addr = -1;
  int first_out = -1;
  int t_done = -1;
  int done_cnt = 0;
  bit saw_addr_vld = 0;
  bit start_req = 0;
  bit err_pulse = 0;
  bit stall_prev = 0;
  logic [PW-1:0] stall_dat = '0;

  function automatic logic [PW-1:0] data_of(input logic [AW-1:0] a);
    return {4{a, ~a}};
  endfunction

  task automatic check_val(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs just after the rising edge, observe on the falling edge.
  task automatic cycle();
    @(posedge clk);
    cyc++;
    #1;
    TOP_Start = start_req;
    if (start_req) begin
      t_start   = cyc;
      start_req = 0;
    end
    if (err_pulse) begin
      bus.GLB_RdDatVld = 1'b1;
      bus.GLB_RdDat    = {4{32'hDEADBEEF}};
      err_pulse        = 0;
    end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      bus.GLB_RdDatVld = 1'b1;
      bus.GLB_RdDat    = pend_q[0].dat;
      pend_q.delete(0);
    end else begin
      bus.GLB_RdDatVld = 1'b0;
      bus.GLB_RdDat    = '0;
    end
    bus.ISA_OutDatRdy = (cyc > hold_until);
    @(negedge clk);

    if (bus.GLB_RdAddrVld) saw_addr_vld = 1;
    if (bus.GLB_RdAddrVld && bus.GLB_RdAddrRdy) begin
      hs_cnt++;
      if (first_addr < 0) first_addr = cyc - t_start;
      if (exp_addr_q.size() == 0) begin
        check_val("addr_extra", 1, 0);
      end else begin
        logic [AW-1:0] ea;
        ea = exp_addr_q.pop_front();
        check_val("rd_addr", bus.GLB_RdAddr, ea);
        pend_q.push_back('{cyc + lat_cur, data_of(ea)});
      end
    end
    if (stall_prev && bus.ISA_OutDatVld) check_val("out_hold", bus.ISA_OutDat, stall_dat);
    if (bus.ISA_OutDatVld && bus.ISA_OutDatRdy) begin
      if (first_out < 0) first_out = cyc - t_start;
      $display("OUT cycle=%0d rel=%0d dat=%h", cyc, cyc - t_start, bus.ISA_OutDat);
      if (exp_q.size() == 0) check_val("out_extra", 1, 0);
      else check_val("out_dat", bus.ISA_OutDat, exp_q.pop_front());
    end
    stall_prev = bus.ISA_OutDatVld && !bus.ISA_OutDatRdy;
    stall_dat  = bus.ISA_OutDat;
    if (TOP_Done) begin
      done_cnt++;
      t_done = cyc - t_start;
      check_val("done_busy", TOP_Busy, 1);
    end
    if (cyc == hold_check) begin
      check_val("hold_hs_cnt", hs_cnt, 4);
      check_val("hold_addr_vld", bus.GLB_RdAddrVld, 0);
    end
  endtask

  task automatic arm(input logic [AW-1:0] base, input logic [NW-1:0] num, input int lat, input int hold);
    lat_cur      = lat;
    hs_cnt       = 0;
    first_addr   = -1;
    first_out    = -1;
    t_done       = -1;
    done_cnt     = 0;
    saw_addr_vld = 0;
    for (int i = 0; i < int'(num); i++) begin
      logic [AW-1:0] a;
      a = base + AW'(i);
      exp_addr_q.push_back(a);
      exp_q.push_back(data_of(a));
    end
    TOP_BaseAddr = base;
    TOP_NumWord  = num;
    start_req    = 1;
    hold_until   = (hold > 0) ? cyc + 1 + hold : 0;
    hold_check   = (hold > 0) ? cyc + 1 + hold : -1;
  endtask

  task automatic run_fetch(input logic [AW-1:0] base, input logic [NW-1:0] num, input int lat, input int hold);
    int budget;
    arm(base, num, lat, hold);
    budget = 0;
    while (done_cnt == 0 && budget < 300) begin
      cycle();
      budget++;
    end
    check_val("done_seen", done_cnt, 1);
    cycle();
    check_val("idle_busy", TOP_Busy, 0);
    check_val("done_pulse_cnt", done_cnt, 1);
    check_val("words_left", exp_q.size(), 0);
    check_val("addrs_left", exp_addr_q.size(), 0);
    $display("RUN base=%h num=%0d lat=%0d done_rel=%0d", base, num, lat, t_done);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, TOP_Busy, 0);
    check_val({tag, "_done"}, TOP_Done, 0);
    check_val({tag, "_err"}, TOP_Err, 0);
    check_val({tag, "_rdaddr"}, bus.GLB_RdAddr, 0);
    check_val({tag, "_rdaddrvld"}, bus.GLB_RdAddrVld, 0);
    check_val({tag, "_outdat"}, bus.ISA_OutDat, 0);
    check_val({tag, "_outvld"}, bus.ISA_OutDatVld, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.GLB_RdAddrRdy = 1'b1;
    bus.GLB_RdDat     = '0;
    bus.GLB_RdDatVld  = 1'b0;
    bus.ISA_OutDatRdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cycle();

    // Basic launch with fixed latency: timing from the start cycle.
    run_fetch(16'h0010, 16'd3, 2, 0);
    check_val("t1_first_addr", first_addr, 1);
    check_val("t1_first_out", first_out, 4);
    check_val("t1_done", t_done, 7);

    // Consumer stalled: issue stops at buffer depth, then resumes.
    run_fetch(16'h0100, 16'd8, 2, 15);
    check_val("t2_hs_total", hs_cnt, 8);

    // Address wrap.
    run_fetch(16'hFFFE, 16'd4, 3, 0);

    // Zero-length launch.
    run_fetch(16'h0055, 16'd0, 2, 0);
    check_val("t4_done", t_done, 1);
    check_val("t4_no_req", saw_addr_vld, 0);

    // Stray GLB data while idle.
    err_pulse = 1;
    repeat (2) cycle();
    check_val("t5_err", TOP_Err, 1);
    check_val("t5_fifo_empty", bus.ISA_OutDatVld, 0);
    run_fetch(16'h0200, 16'd2, 1, 0);
    check_val("t5_err_sticky", TOP_Err, 1);

    // Reset in FETCH with two words buffered.
    arm(16'h0300, 16'd8, 2, 100);
    repeat (6) cycle();
    check_val("t6_buffered", bus.ISA_OutDatVld, 1);
    check_val("t6_fetching", TOP_Busy, 1);
    #1;
    rst_n = 1'b0;
    bus.GLB_RdDatVld = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    exp_addr_q.delete();
    pend_q.delete();
    stall_prev = 0;
    hold_until = 0;
    hold_check = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_fetch(16'h0400, 16'd2, 2, 0);
    check_val("t6_first_addr", first_addr, 1);
    check_val("t6_err_clear", TOP_Err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/isa_fetch_ctrl.md
# isa_fetch_ctrl

Sequencer that streams a block of ISA words from a global-buffer read port into the configuration controller's ISA input. It generates consecutive read addresses and tracks outstanding reads with a credit counter, so its internal FIFO never overflows. Buffered words are presented on a valid/ready stream. It sits between the top-level launch logic, one GLB read port, and the CCU ISA input (`ITFCCU_ISARdDat` / `ITFCCU_ISARdDatVld` / `CCUITF_ISARdDatRdy`).

## Interface
- PORT_WIDTH, 128, ISA word width (one GLB read beat).
- ADDR_WIDTH, 16, GLB word address width.
- NUMWORD_WIDTH, 16, width of the word-count field.
- FIFO_ADDR_WIDTH, 2, log2 of FIFO depth (depth D = 4 by default).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- TOP_Start  in  1  single-cycle launch pulse; sampled only in IDLE
- TOP_BaseAddr  in  ADDR_WIDTH  first word address; sampled with TOP_Start
- TOP_NumWord  in  NUMWORD_WIDTH  number of words to fetch; sampled with TOP_Start
- TOP_Busy  out  1  high in every state except IDLE
- TOP_Done  out  1  one-cycle completion pulse
- TOP_Err  out  1  sticky flag for read data arriving with no read outstanding; cleared only by reset
- GLB_RdAddr  out  ADDR_WIDTH  read address
- GLB_RdAddrVld  out  1  read request valid
- GLB_RdAddrRdy  in  1  read request accepted
- GLB_RdDat  in  PORT_WIDTH  read data
- GLB_RdDatVld  in  1  read data valid; no backpressure, variable latency, returned in order
- ISA_OutDat  out  PORT_WIDTH  ISA word to the CCU
- ISA_OutDatVld  out  1  ISA word valid
- ISA_OutDatRdy  in  1  CCU ready

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE
  - TOP_Start with NumWord≠0: latch base and count, clear issued count, go to FETCH.
  - TOP_Start with NumWord=0: go to DONE.
  - TOP_Start outside IDLE is ignored.
- FETCH
  - GLB_RdAddrVld = (issued < NumWord) & (credit > 0).
  - credit = D − fifo_count − outstanding, computed with FIFO_ADDR_WIDTH+1 bits.
  - On an address handshake: address += 1 (wraps modulo 2^ADDR_WIDTH), issued += 1, outstanding += 1.
  - Go to DRAIN when the last address handshake completes.
- outstanding counter
  - Decrements on GLB_RdDatVld.
  - Simultaneous address handshake and data return leave it unchanged.
  - Data return with outstanding=0 sets TOP_Err; that data is discarded (no push, no decrement).
- FIFO
  - Depth D, pushed on valid GLB_RdDatVld, popped on ISA_OutDatVld & ISA_OutDatRdy.
  - Simultaneous push and pop is legal at any fill level; count is unchanged.
  - The credit rule makes push-when-full unreachable.
- ISA_OutDat/ISA_OutDatVld come from the registered FIFO head (FWFT). Data must hold stable while Vld=1 and Rdy=0.
- DRAIN: go to DONE when outstanding=0, FIFO empty, and no push in the current cycle.
- DONE: TOP_Done=1 for exactly one cycle, then IDLE.
- rst_n asserted mid-operation: all state, counters, FIFO and TOP_Err clear immediately. In-flight GLB data is not tracked after reset, so the launcher must not release reset with reads outstanding.

## Timing
- Reset value of every output is 0: Busy, Done, Err, RdAddr, RdAddrVld, OutDat, OutDatVld.
- TOP_Start in cycle 0: FETCH in cycle 1; GLB_RdAddrVld=1 with GLB_RdAddr=BaseAddr in cycle 1.
- Back-to-back issue: one address per cycle while credit>0 and GLB_RdAddrRdy=1.
- GLB_RdDatVld in cycle t: ISA_OutDatVld=1 with that word in cycle t+1 (FIFO empty, no pop in t).
- Peak throughput: one word per cycle, given sustained CCU ready and a GLB latency below D cycles.
- Final output handshake in cycle t (outstanding=0): DONE in t+1 (TOP_Done=1, Busy=1), IDLE in t+2 (Busy=0).
- NumWord=0: Start in cycle 0, TOP_Done=1 in cycle 1, no GLB request issued.

## Test plan
- Base=0x0010, NumWord=3, GLB latency 2, Rdy always 1 -> addresses 0x10,0x11,0x12 in cycles 1-3; words out in order at cycles 4-6; TOP_Done in cycle 7.
- NumWord=8, D=4, ISA_OutDatRdy=0 held -> exactly 4 address handshakes, then RdAddrVld=0. Releasing Rdy resumes issue; all 8 words delivered in order; no loss.
- Base=0xFFFE, NumWord=4 -> addresses 0xFFFE,0xFFFF,0x0000,0x0001.
- NumWord=0 -> TOP_Done pulse in cycle 1, GLB_RdAddrVld never asserted.
- GLB_RdDatVld pulsed in IDLE -> TOP_Err=1 and stays 1, FIFO stays empty. A following Start with NumWord=2 still completes normally.
- rst_n asserted during FETCH with 2 words buffered -> all outputs 0 immediately. A new Start after release works from a clean state.
